uart_tx_core: RTL and testbench
===============================

# uart_tx_core

UART transmitter: accepts one parallel byte per valid/ready handshake and shifts it out LSB first on a single serial line as a start bit, data bits, optional even-parity bit and stop bit(s). It holds its own 1x bit-period divider, CLK_DIV clocks per bit, which restarts at every frame. It is the transmit counterpart of the UART receive path and sits between the host-side byte source and the `tx` pad.

## Interface
- `CLK_DIV`, 40, clocks per serial bit. Legal range is ≥ 2. 40 equals 8 receiver oversample ticks of 5 clocks each.
- `DATA_BITS`, 8, data bits per frame. Legal range is 5–9.
- `STOP_BITS`, 1, stop bits per frame. Legal values are 1 or 2.
- `clk`  in  1  system clock. Single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_BITS  byte to send. Sampled only on handshake.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a byte. Reset value 1.
- `tx`  out  1  serial line. Idle level is 1. Reset value 1.
- `tx_busy`  out  1  frame in progress. Reset value 0.
- `tx_done`  out  1  single-cycle pulse at the end of the frame. Reset value 0.

## Operation
- States and transitions:
  - IDLE → START on handshake (`tx_valid && tx_ready`).
  - START → DATA.
  - DATA → PARITY when `UART_TX_PARITY_EN` is defined, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Handshake occurs only in IDLE. On handshake, `tx_data` is latched into a shift register, parity is computed from the latched value, and the bit counter and divider clear.
- `tx_ready` is 1 only in IDLE and is driven combinationally from state. `tx_busy` is the inverse of `tx_ready`.
- `tx` is registered:
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0; the register shifts right once per bit period.
  - PARITY: XOR of all latched data bits (even parity).
  - STOP: 1.
- Divider counts 0..CLK_DIV-1. A bit ends when the count equals CLK_DIV-1, then the count wraps to 0.
- Bit counter counts 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
- `tx_done` asserts in the last clock of the final stop bit, the same cycle the FSM leaves STOP.
- While not ready, `tx_valid` is ignored and `tx_data` changes have no effect. `tx_valid` asserted with no handshake is not an error.
- Reset at any point, including mid-frame:
  - frame aborted and latched byte discarded;
  - `tx` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0 immediately;
  - all counters cleared.

## Timing
- Handshake in cycle t: `tx` falls to 0 at t+1.
- Each bit is held for exactly CLK_DIV cycles.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, where P = 1 with parity and P = 0 without.
- `tx_done` is high in cycle t+F. The FSM is in IDLE with `tx_ready` = 1 at t+F+1.
- Back-to-back: with `tx_valid` held high, the next handshake is at t+F+1 and the next start bit at t+F+2. This gives one idle-high cycle between frames, which is required behaviour.
- No combinational path from `tx_valid` or `tx_data` to `tx`.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is present;
  - one even-parity bit is sent after the MSB;
  - F includes P = 1.
- `UART_TX_PARITY_EN` undefined:
  - PARITY state and parity logic are absent;
  - the stop bit follows the MSB directly.

## Test plan
Unless stated otherwise: CLK_DIV=4, DATA_BITS=8, STOP_BITS=1.

- **Reset:** hold `reset_n`=0 for 3 cycles, then release → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 before and after release.
- **Single frame, no parity:** send `tx_data`=8'hA5 with a one-cycle `tx_valid` → `tx` sequence of 4-cycle bits is 0,1,0,1,0,0,1,0,1,1. `tx_done` is high at handshake+40 only; `tx_ready` returns at handshake+41.
- **Parity enabled:** send `tx_data`=8'h07 → parity bit 1 after the MSB. Send `tx_data`=8'h03 → parity bit 0. Frame length is 44 cycles.
- **Back-to-back:** hold `tx_valid`=1 and send 8'h55 then 8'hAA → exactly one `tx`=1 idle cycle between the first stop bit and the second start bit. `tx_done` pulses twice, 41 cycles apart.
- **Busy and data stability:** change `tx_data` from 8'h0F to 8'hF0 in mid-frame with `tx_valid`=1 → 8'h0F is transmitted unchanged and no second handshake occurs until `tx_ready`=1.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 3 → `tx`=1 in the same cycle with no clock edge. After release, no `tx_done` is produced and the next handshake sends a complete fresh frame.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter. Takes one word per valid/ready handshake and
// sends it LSB first as start bit, DATA_BITS data bits, an optional even-parity
// bit and STOP_BITS stop bits, each held for CLK_DIV clocks.
// Optional feature: define UART_TX_PARITY_EN to insert the even-parity bit.
module uart_tx_core #(
  parameter int CLK_DIV   = 40,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   handshake;
  logic                   bit_end;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  // Only IDLE accepts a word; busy is simply the complement.
  assign tx_ready  = (state_q == S_IDLE);
  assign tx_busy   = ~tx_ready;
  assign handshake = tx_valid && tx_ready;
  assign bit_end   = (div_q == DIV_LAST);
  assign tx        = tx_q;

  // Next-state, counter, shift and registered-line logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    div_d    = (state_q == S_IDLE || bit_end) ? '0 : div_q + DIV_W'(1);
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d  = S_START;
          shreg_d  = tx_data;
          bit_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            tx_done = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line level is a function of where the FSM is going, so it can be
    // registered and still change on the same edge as the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and line register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shift register is reset along with the control state so an
      // aborted frame leaves no stale word behind.
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench for uart_tx_core with CLK_DIV=4, DATA_BITS=8,
// STOP_BITS=1. Expected line sequences are hand-written frame vectors; the
// parity variants are selected by UART_TX_PARITY_EN.
module tb_uart_tx_core;

  localparam int CLK_DIV   = 4;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DATA_BITS + P + STOP_BITS;
  localparam int F     = NBITS * CLK_DIV;

  // Frame vectors, bit 0 is the first bit on the line (start bit).
`ifdef UART_TX_PARITY_EN
  localparam logic [NBITS-1:0] V_A5 = 11'b1_0_10100101_0;
  localparam logic [NBITS-1:0] V_07 = 11'b1_1_00000111_0;
  localparam logic [NBITS-1:0] V_03 = 11'b1_0_00000011_0;
  localparam logic [NBITS-1:0] V_55 = 11'b1_0_01010101_0;
  localparam logic [NBITS-1:0] V_AA = 11'b1_0_10101010_0;
  localparam logic [NBITS-1:0] V_0F = 11'b1_0_00001111_0;
  localparam logic [NBITS-1:0] V_3C = 11'b1_0_00111100_0;
`else
  localparam logic [NBITS-1:0] V_A5 = 10'b1_10100101_0;
  localparam logic [NBITS-1:0] V_07 = 10'b1_00000111_0;
  localparam logic [NBITS-1:0] V_03 = 10'b1_00000011_0;
  localparam logic [NBITS-1:0] V_55 = 10'b1_01010101_0;
  localparam logic [NBITS-1:0] V_AA = 10'b1_10101010_0;
  localparam logic [NBITS-1:0] V_0F = 10'b1_00001111_0;
  localparam logic [NBITS-1:0] V_3C = 10'b1_00111100_0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [DATA_BITS-1:0] tx_data = '0;
  logic                 tx_valid = 1'b0;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_core #(
    .CLK_DIV  (CLK_DIV),
    .DATA_BITS(DATA_BITS),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, tx, 1);
    check({tag, " ready"}, tx_ready, 1);
    check({tag, " busy"}, tx_busy, 0);
    check({tag, " done"}, tx_done, 0);
  endtask

  // Called at a falling edge with the DUT idle. Handshakes on the next rising
  // edge (cycle t), checks tx and tx_done in every cycle t+1..t+F, then checks
  // the idle gap at t+F+1 and returns at that falling edge.
  // pulse: drop tx_valid right after the handshake; keep: leave tx_valid high
  // at the end so the next call handshakes back-to-back; change: swap tx_data
  // to alt in mid-frame.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic [NBITS-1:0] bits,
                            input bit pulse, input bit keep, input bit change,
                            input logic [DATA_BITS-1:0] alt);
    string tag;
    tag = $sformatf("frame %02h", d);
    check({tag, " ready_pre"}, tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (pulse) tx_valid = 1'b0;
    for (int k = 1; k <= F; k++) begin
      @(negedge clk);
      check($sformatf("%s tx c%0d", tag, k), tx, bits[(k-1)/CLK_DIV]);
      check($sformatf("%s done c%0d", tag, k), tx_done, (k == F));
      if (k == 2 || k == F) begin
        check($sformatf("%s busy c%0d", tag, k), tx_busy, 1);
        check($sformatf("%s ready c%0d", tag, k), tx_ready, 0);
      end
      if (change && k == F / 2) tx_data = alt;
    end
    @(negedge clk);
    check({tag, " gap tx"}, tx, 1);
    check({tag, " gap ready"}, tx_ready, 1);
    check({tag, " gap done"}, tx_done, 0);
    if (!keep) tx_valid = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles, then released.
    repeat (3) begin
      @(negedge clk);
      check_idle("in_reset");
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle("after_reset");
    end

    // Single frames with a one-cycle valid.
    send_frame(8'hA5, V_A5, 1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(8'h07, V_07, 1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(8'h03, V_03, 1'b1, 1'b0, 1'b0, 8'h00);

    // Back-to-back with valid held: one idle cycle between frames.
    send_frame(8'h55, V_55, 1'b0, 1'b1, 1'b0, 8'h00);
    send_frame(8'hAA, V_AA, 1'b0, 1'b0, 1'b0, 8'h00);

    // Data changed mid-frame with valid high is ignored.
    send_frame(8'h0F, V_0F, 1'b0, 1'b0, 1'b1, 8'hF0);
    repeat (6) begin
      @(negedge clk);
      check_idle("post_0F");
    end

    // Reset during data bit 3 of 8'hC3 (bit 3 is 0, cycles t+17..t+20).
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("abort pre tx", tx, 0);
    check("abort pre busy", tx_busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("abort async");
    repeat (2) begin
      @(negedge clk);
      check_idle("abort held");
    end
    reset_n = 1'b1;
    for (int k = 0; k < F + 8; k++) begin
      @(negedge clk);
      check($sformatf("abort quiet tx c%0d", k), tx, 1);
      check($sformatf("abort quiet done c%0d", k), tx_done, 0);
    end

    // Fresh complete frame after the abort.
    send_frame(8'h3C, V_3C, 1'b1, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
